// File: rtl/term_pkg.sv
// Shared constants, state enum and write-command type for the text terminal controller.
package term_pkg;

  localparam int unsigned COLS_DEF  = 80;
  localparam int unsigned ROWS_DEF  = 25;
  localparam int unsigned CELLS_DEF = COLS_DEF * ROWS_DEF;
  localparam int unsigned CUR_W     = 11;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_CHAR,
    S_SCROLL_COPY,
    S_SCROLL_FILL
  } state_e;

  typedef struct packed {
    logic [CUR_W-1:0] cbeg;
    logic [CUR_W-1:0] cend;
    logic [7:0]       data;
    logic [7:0]       offset;
  } wr_cmd_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/term_ctrl_if.sv
// Byte-input handshake and buffer-write command bus of the terminal controller.
interface term_ctrl_if;
  import term_pkg::*;

  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic [CUR_W-1:0] cursor;
  logic             wr_start;
  logic [CUR_W-1:0] wr_begin;
  logic [CUR_W-1:0] wr_end;
  logic [7:0]       wr_data;
  logic [7:0]       wr_offset;
  logic             wr_complete;

  modport master (
    input  in_valid, in_data, wr_complete,
    output in_ready, cursor, wr_start, wr_begin, wr_end, wr_data, wr_offset
  );

  modport slave (
    output in_valid, in_data, wr_complete,
    input  in_ready, cursor, wr_start, wr_begin, wr_end, wr_data, wr_offset
  );

endinterface

// File: rtl/term_wr_cmd.sv
// Write-command issuer: one-cycle start pulse, held command fields, outstanding flag.
module term_wr_cmd
  import term_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    issue_i,
  input  wr_cmd_t cmd_i,
  input  logic    wr_complete_i,
  output logic    wr_start_o,
  output wr_cmd_t cmd_o,
  output logic    busy_o,
  output logic    done_o
);

  logic    start_q, start_d;
  logic    busy_q, busy_d;
  wr_cmd_t cmd_q, cmd_d;

  // Completions arriving with nothing outstanding are dropped here.
  assign done_o = busy_q && wr_complete_i;

  always_comb begin
    start_d = issue_i && !busy_q;
    busy_d  = busy_q;
    cmd_d   = cmd_q;
    if (start_d) begin
      busy_d = 1'b1;
      cmd_d  = cmd_i;
    end else if (done_o) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      cmd_q   <= '{cbeg: '0, cend: '0, data: CH_SPACE, offset: 8'h00};
    end else begin
      start_q <= start_d;
      busy_q  <= busy_d;
      cmd_q   <= cmd_d;
    end
  end

  assign wr_start_o = start_q;
  assign cmd_o      = cmd_q;
  assign busy_o     = busy_q;

endmodule

// File: rtl/term_ctrl.sv
// Text terminal controller: turns a byte stream into buffer fill/copy commands.
// Optional TERM_TAB_EN enables horizontal tab handling (otherwise 0x09 is ignored).
module term_ctrl
  import term_pkg::*;
#(
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned ROWS = ROWS_DEF
) (
  input  logic         clk100,
  input  logic         rst,
  term_ctrl_if.master  bus
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam logic [CUR_W-1:0] CellsW   = CUR_W'(CELLS);
  localparam logic [CUR_W-1:0] LastRowW = CUR_W'(CELLS - COLS);
  localparam logic [CUR_W-1:0] ColsW    = CUR_W'(COLS);

  state_e           state_q, state_d;
  logic [CUR_W-1:0] cursor_q, cursor_d;
  logic [7:0]       col_q, col_d;
  logic [7:0]       row_q, row_d;
  logic [7:0]       byte_q, byte_d;

  logic    issue, busy, done, in_ready;
  wr_cmd_t cmd, cmd_out;

  assign in_ready = (state_q == S_IDLE) && !busy;

`ifdef TERM_TAB_EN
  logic [7:0] tab_col;
  // Next multiple-of-8 column, clamped to the last column; never wraps.
  always_comb begin
    tab_col = {col_q[7:3] + 5'd1, 3'b000};
    if (tab_col > 8'(COLS - 1)) tab_col = 8'(COLS - 1);
  end
`endif

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    col_d    = col_q;
    row_d    = row_q;
    byte_d   = byte_q;
    issue    = 1'b0;
    cmd      = '{cbeg: '0, cend: CellsW, data: CH_SPACE, offset: 8'h00};
    case (state_q)
      S_CLEAR: begin
        issue = 1'b1;
        if (done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.in_valid && in_ready) begin
          if (is_printable(bus.in_data)) begin
            byte_d  = bus.in_data;
            state_d = S_CHAR;
          end else begin
            case (bus.in_data)
              CH_CR: begin
                cursor_d = cursor_q - CUR_W'(col_q);
                col_d    = 8'h00;
              end
              CH_LF: begin
                // Last row keeps its column; the screen scrolls underneath it.
                if (row_q == 8'(ROWS - 1)) begin
                  state_d = S_SCROLL_COPY;
                end else begin
                  cursor_d = cursor_q + ColsW;
                  row_d    = row_q + 8'd1;
                end
              end
              CH_BS: begin
                if (col_q != 8'h00) begin
                  cursor_d = cursor_q - CUR_W'(1);
                  col_d    = col_q - 8'd1;
                end
              end
`ifdef TERM_TAB_EN
              CH_TAB: begin
                cursor_d = cursor_q + CUR_W'(tab_col - col_q);
                col_d    = tab_col;
              end
`endif
              default: ;
            endcase
          end
        end
      end
      S_CHAR: begin
        issue = 1'b1;
        cmd   = '{cbeg: cursor_q, cend: cursor_q + CUR_W'(1), data: byte_q, offset: 8'h00};
        if (done) begin
          if (cursor_q == CellsW - CUR_W'(1)) begin
            cursor_d = LastRowW;
            col_d    = 8'h00;
            row_d    = 8'(ROWS - 1);
            state_d  = S_SCROLL_COPY;
          end else begin
            cursor_d = cursor_q + CUR_W'(1);
            state_d  = S_IDLE;
            if (col_q == 8'(COLS - 1)) begin
              col_d = 8'h00;
              row_d = row_q + 8'd1;
            end else begin
              col_d = col_q + 8'd1;
            end
          end
        end
      end
      S_SCROLL_COPY: begin
        issue = 1'b1;
        cmd   = '{cbeg: '0, cend: LastRowW, data: CH_SPACE, offset: 8'(COLS)};
        if (done) state_d = S_SCROLL_FILL;
      end
      S_SCROLL_FILL: begin
        issue = 1'b1;
        cmd   = '{cbeg: LastRowW, cend: CellsW, data: CH_SPACE, offset: 8'h00};
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q  <= S_CLEAR;
      cursor_q <= '0;
      col_q    <= 8'h00;
      row_q    <= 8'h00;
      byte_q   <= CH_SPACE;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      col_q    <= col_d;
      row_q    <= row_d;
      byte_q   <= byte_d;
    end
  end

  term_wr_cmd u_wr_cmd (
    .clk_i        (clk100),
    .rst_i        (rst),
    .issue_i      (issue),
    .cmd_i        (cmd),
    .wr_complete_i(bus.wr_complete),
    .wr_start_o   (bus.wr_start),
    .cmd_o        (cmd_out),
    .busy_o       (busy),
    .done_o       (done)
  );

  assign bus.in_ready  = in_ready;
  assign bus.cursor    = cursor_q;
  assign bus.wr_begin  = cmd_out.cbeg;
  assign bus.wr_end    = cmd_out.cend;
  assign bus.wr_data   = cmd_out.data;
  assign bus.wr_offset = cmd_out.offset;

endmodule

// File: doc/term_ctrl.md
TERM_CTRL -- requirements
Module: term_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text columns per row.
REQ-002 SHALL have parameter ROWS, default 25, meaning text rows on screen (CELLS = COLS*ROWS = 2000).
REQ-003 SHALL have port clk100  input  1  system clock; all logic on its rising edge; one clock only.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input byte available.
REQ-006 SHALL have port in_data  input  8  input character byte.
REQ-007 SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-008 SHALL have port cursor  output  11  linear cell index of the cursor, 0..CELLS-1.
REQ-009 SHALL have port wr_start  output  1  one-cycle pulse issuing a buffer-write command.
REQ-010 SHALL have ports wr_begin and wr_end  output  11 each  command range [wr_begin, wr_end), end exclusive.
REQ-011 SHALL have port wr_data  output  8  fill byte, used when wr_offset == 0.
REQ-012 SHALL have port wr_offset  output  8  0 = fill with wr_data; N = copy cell addr+N to addr.
REQ-013 SHALL have port wr_complete  input  1  one-cycle pulse ending the outstanding command.

Function
REQ-014 SHALL run FSM states S_CLEAR, S_IDLE, S_CHAR, S_SCROLL_COPY, S_SCROLL_FILL; each command state issues one command, then waits.
REQ-015 SHALL assert in_ready only in S_IDLE with no command outstanding.
REQ-016 SHALL pulse wr_start exactly one cycle per command, hold wr_begin/wr_end/wr_data/wr_offset stable from that pulse until wr_complete, and never issue a new command before wr_complete.
REQ-017 SHALL treat bytes 0x20..0x7E as printable: issue {begin=cursor, end=cursor+1, data=byte, offset=0} in S_CHAR; on wr_complete, advance cursor by 1.
REQ-018 SHALL, when an advance reaches CELLS, enter S_SCROLL_COPY issuing {0, CELLS-COLS, offset=COLS}, then S_SCROLL_FILL issuing {CELLS-COLS, CELLS, data=0x20, offset=0}, and set cursor = CELLS-COLS.
REQ-019 SHALL handle 0x0D (CR) by setting cursor to the start of its row, one cycle, no command.
REQ-020 SHALL handle 0x0A (LF) by adding COLS to cursor, or, on the last row, keeping the column and scrolling per REQ-018.
REQ-021 SHALL handle 0x08 (BS) by decrementing cursor when column != 0, no erase; at column 0, no change.
REQ-022 SHALL ignore all other bytes (accept, no state change, in_ready high next cycle).
REQ-023 SHALL track column and row in counters; no divide/modulo on cursor.
REQ-024 SHALL ignore wr_complete when no command is outstanding.

Reset
REQ-025 SHALL on rst set cursor=0, wr_start=0, wr_begin=0, wr_end=0, wr_data=0x20, wr_offset=0, in_ready=0, state S_CLEAR.
REQ-026 SHALL in S_CLEAR, one cycle after rst deasserts, issue {0, CELLS, 0x20, 0}, then enter S_IDLE on wr_complete.
REQ-027 SHALL on rst mid-command abandon the command, discard the pending byte, and restart from S_CLEAR.

Configuration
REQ-028 SHALL, with TERM_TAB_EN defined, handle 0x09 by advancing cursor to the next multiple-of-8 column, clamped to COLS-1, no command, no wrap.
REQ-029 SHALL, without TERM_TAB_EN, treat 0x09 as ignored per REQ-022.

Structure
REQ-030 SHALL place COLS/ROWS/CELLS defaults, CH_SPACE/CH_CR/CH_LF/CH_BS/CH_TAB constants and the state enum in shared package term_pkg.
REQ-031 SHALL contain one sub-module term_wr_cmd owning the wr_start pulse, the outstanding flag and the wr_complete wait.

Verification
REQ-032 SHALL cover: reset released -> one command {0,2000,0x20,0}; in_ready=0 until wr_complete; then cursor=0, in_ready=1.
REQ-033 SHALL cover: "A" (0x41) at cursor 0 -> command {0,1,0x41,0}; after wr_complete cursor=1.
REQ-034 SHALL cover: cursor=1999, byte 0x42 -> {1999,2000,0x42,0}, {0,1920,_,80}, {1920,2000,0x20,0}; final cursor=1920.
REQ-035 SHALL cover: cursor=1925, CR -> 1920; LF -> scroll pair issued, cursor stays 1920; BS at 1920 -> 1920.
REQ-036 SHALL cover: rst pulsed while scroll copy outstanding -> abandon, fresh clear command, cursor=0; stray wr_complete in S_IDLE ignored.
REQ-037 SHALL cover: cursor=3, 0x09 -> 8 with TERM_TAB_EN, 3 without; cursor=78 -> 79 with TERM_TAB_EN.
